// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the column configuration write path.
//   - fsm_state_e        : write sequencer state encoding
//   - DefMaxFramesPerCol : default number of FrameStrobe lines per column
//   - DefFrameBitsPerRow : default FrameData width
//   - addr_legal()       : true when a frame address targets an existing strobe line
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } fsm_state_e;

    localparam int unsigned DefMaxFramesPerCol = 20;
    localparam int unsigned DefFrameBitsPerRow = 32;

    function automatic logic addr_legal(input int unsigned addr, input int unsigned max_frames);
        return addr < max_frames;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with enable.
//   en_i     : when low, onehot_o is all zeros
//   addr_i   : index of the bit to raise
//   onehot_o : Width-wide one-hot (or zero) vector
module onehot_decoder #(
    parameter int unsigned Width     = 20,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic [Width-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            for (int unsigned i = 0; i < Width; i++) begin
                if (addr_i == AddrWidth'(i)) begin
                    onehot_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Column-level configuration frame write controller.
// Accepts (frame address, data word) commands and runs each write through a
// setup / strobe / hold sequence on the column's FrameData and FrameStrobe lines.
//   UserCLK, RST        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_frame_addr      : target frame index
//   cmd_data            : frame word
//   abort               : cancels a write while still in setup
//   FrameData           : column data bus (held between writes)
//   FrameStrobe         : one-hot frame strobe
//   busy                : a write is in progress
//   done/err/aborted    : single-cycle status pulses
//   frames_written      : saturating count of completed writes
module frame_strobe_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = DefMaxFramesPerCol,
    parameter int unsigned FrameBitsPerRow = DefFrameBitsPerRow,
    parameter int unsigned AddrWidth       = 5,
    parameter int unsigned SetupCycles     = 1,
    parameter int unsigned StrobeCycles    = 1,
    parameter int unsigned HoldCycles      = 1,
    parameter int unsigned CntWidth        = 16
) (
    input  logic                       UserCLK,
    input  logic                       RST,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [AddrWidth-1:0]       cmd_frame_addr,
    input  logic [FrameBitsPerRow-1:0] cmd_data,
    input  logic                       abort,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       aborted,
    output logic [CntWidth-1:0]        frames_written
);

    localparam int unsigned MaxPhase = (SetupCycles > StrobeCycles) ?
        ((SetupCycles > HoldCycles) ? SetupCycles : HoldCycles) :
        ((StrobeCycles > HoldCycles) ? StrobeCycles : HoldCycles);
    // Counter holds remaining cycles minus one, so MaxPhase-1 is the largest value.
    localparam int unsigned PhaseWidth = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;

    localparam logic [PhaseWidth-1:0] SetupLoad  = PhaseWidth'(SetupCycles - 1);
    localparam logic [PhaseWidth-1:0] StrobeLoad = PhaseWidth'(StrobeCycles - 1);
    localparam logic [PhaseWidth-1:0] HoldLoad   = PhaseWidth'(HoldCycles - 1);

    fsm_state_e                 state_q, state_d;
    logic [PhaseWidth-1:0]      phase_q, phase_d;
    logic [AddrWidth-1:0]       addr_q, addr_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic [CntWidth-1:0]        frames_q, frames_d;
    logic                       ready_q, busy_q;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        addr_d    = addr_q;
        data_d    = data_q;
        frames_d  = frames_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    if (addr_legal(32'(cmd_frame_addr), MaxFramesPerCol)) begin
                        state_d = StSetup;
                        phase_d = SetupLoad;
                        addr_d  = cmd_frame_addr;
                        data_d  = cmd_data;
                    end else begin
                        // Consumed but rejected: bus and strobe untouched.
                        err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                // Abort wins over the transition into STROBE, so no strobe is issued.
                if (abort) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (phase_q == '0) begin
                    state_d = StStrobe;
                    phase_d = StrobeLoad;
                end else begin
                    phase_d = phase_q - PhaseWidth'(1);
                end
            end
            StStrobe: begin
                if (phase_q == '0) begin
                    state_d = StHold;
                    phase_d = HoldLoad;
                end else begin
                    phase_d = phase_q - PhaseWidth'(1);
                end
            end
            StHold: begin
                if (phase_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (frames_q != '1) begin
                        frames_d = frames_q + CntWidth'(1);
                    end
                end else begin
                    phase_d = phase_q - PhaseWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobe is decoded from the next state and registered, so the output
    // flop switches cleanly with no decode glitches on the column lines.
    onehot_decoder #(
        .Width     (MaxFramesPerCol),
        .AddrWidth (AddrWidth)
    ) u_strobe_dec (
        .en_i     (state_d == StStrobe),
        .addr_i   (addr_q),
        .onehot_o (strobe_d)
    );

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
            frames_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            frames_q  <= frames_d;
            ready_q   <= (state_d == StIdle);
            busy_q    <= (state_d != StIdle);
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready      = ready_q;
    assign busy           = busy_q;
    assign FrameData      = data_q;
    assign FrameStrobe    = strobe_q;
    assign done           = done_q;
    assign err            = err_q;
    assign aborted        = aborted_q;
    assign frames_written = frames_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer. Three instances share clock and reset:
//   a: default timing, b: setup/strobe/hold = 3/2/2, c: 4-bit frame counter.
module tb_frame_strobe_sequencer;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    logic        a_valid, a_ready, a_abort, a_busy, a_done, a_err, a_aborted;
    logic [4:0]  a_addr;
    logic [31:0] a_data, a_fdata;
    logic [19:0] a_strobe;
    logic [15:0] a_frames;

    logic        b_valid, b_ready, b_abort, b_busy, b_done, b_err, b_aborted;
    logic [4:0]  b_addr;
    logic [31:0] b_data, b_fdata;
    logic [19:0] b_strobe;
    logic [15:0] b_frames;

    logic        c_valid, c_ready, c_abort, c_busy, c_done, c_err, c_aborted;
    logic [4:0]  c_addr;
    logic [31:0] c_data, c_fdata;
    logic [19:0] c_strobe;
    logic [3:0]  c_frames;

    frame_strobe_sequencer u_a (
        .UserCLK(clk), .RST(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_frame_addr(a_addr), .cmd_data(a_data), .abort(a_abort), .FrameData(a_fdata),
        .FrameStrobe(a_strobe), .busy(a_busy), .done(a_done), .err(a_err),
        .aborted(a_aborted), .frames_written(a_frames)
    );

    frame_strobe_sequencer #(
        .SetupCycles(3), .StrobeCycles(2), .HoldCycles(2)
    ) u_b (
        .UserCLK(clk), .RST(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_frame_addr(b_addr), .cmd_data(b_data), .abort(b_abort), .FrameData(b_fdata),
        .FrameStrobe(b_strobe), .busy(b_busy), .done(b_done), .err(b_err),
        .aborted(b_aborted), .frames_written(b_frames)
    );

    frame_strobe_sequencer #(
        .CntWidth(4)
    ) u_c (
        .UserCLK(clk), .RST(rst), .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_frame_addr(c_addr), .cmd_data(c_data), .abort(c_abort), .FrameData(c_fdata),
        .FrameStrobe(c_strobe), .busy(c_busy), .done(c_done), .err(c_err),
        .aborted(c_aborted), .frames_written(c_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one strobe line may be high on any cycle, on every instance.
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if ($countones(a_strobe) > 1 || $countones(b_strobe) > 1 ||
                $countones(c_strobe) > 1) begin
                $display("FAIL onehot: a=%h b=%h c=%h, required popcount <= 1",
                         a_strobe, b_strobe, c_strobe);
                n_err++;
            end
        end
    end

    // Advance one clock; observe just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #10;
        n_vec++; if (a_strobe !== 20'h0) begin $display("FAIL rst_strobe: got %h want 0", a_strobe); n_err++; end
        n_vec++; if (a_fdata !== 32'h0) begin $display("FAIL rst_fdata: got %h want 0", a_fdata); n_err++; end
        n_vec++; if (a_frames !== 16'h0) begin $display("FAIL rst_frames: got %0d want 0", a_frames); n_err++; end
        n_vec++; if ({a_done, a_err, a_aborted, a_busy} !== 4'b0) begin
            $display("FAIL rst_flags: got %b want 0000", {a_done, a_err, a_aborted, a_busy}); n_err++; end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        n_vec++; if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            $display("FAIL rst_ready: got %b want 111", {a_ready, b_ready, c_ready}); n_err++; end
    endtask

    task automatic test_basic_write();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hA5A5_0F0F;
        tick();  // T+1
        a_valid = 1'b0;
        n_vec++; if (a_fdata !== 32'hA5A5_0F0F) begin $display("FAIL basic_fdata: got %h want a5a50f0f", a_fdata); n_err++; end
        n_vec++; if (a_strobe !== 20'h0) begin $display("FAIL basic_setup_strobe: got %h want 0", a_strobe); n_err++; end
        n_vec++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL basic_busy: got ready=%b busy=%b want 0/1", a_ready, a_busy); n_err++; end
        tick();  // T+2
        n_vec++; if (a_strobe !== 20'h00020) begin $display("FAIL basic_strobe: got %h want 00020", a_strobe); n_err++; end
        tick();  // T+3
        n_vec++; if (a_strobe !== 20'h0 || a_done !== 1'b0) begin
            $display("FAIL basic_hold: got strobe=%h done=%b want 0/0", a_strobe, a_done); n_err++; end
        n_vec++; if (a_fdata !== 32'hA5A5_0F0F) begin $display("FAIL basic_hold_data: got %h want a5a50f0f", a_fdata); n_err++; end
        tick();  // T+4
        n_vec++; if (a_done !== 1'b1 || a_ready !== 1'b1) begin
            $display("FAIL basic_done: got done=%b ready=%b want 1/1", a_done, a_ready); n_err++; end
        n_vec++; if (a_frames !== 16'd1) begin $display("FAIL basic_frames: got %0d want 1", a_frames); n_err++; end
        tick();  // T+5
        n_vec++; if (a_done !== 1'b0) begin $display("FAIL basic_done_pulse: got %b want 0", a_done); n_err++; end
    endtask

    task automatic test_illegal_addr();
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hDEAD_BEEF;
        tick();
        a_valid = 1'b0;
        n_vec++; if (a_err !== 1'b1) begin $display("FAIL illegal_err: got %b want 1", a_err); n_err++; end
        n_vec++; if (a_strobe !== 20'h0) begin $display("FAIL illegal_strobe: got %h want 0", a_strobe); n_err++; end
        n_vec++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
            $display("FAIL illegal_ready: got ready=%b busy=%b want 1/0", a_ready, a_busy); n_err++; end
        n_vec++; if (a_fdata !== 32'hA5A5_0F0F) begin $display("FAIL illegal_fdata: got %h want a5a50f0f", a_fdata); n_err++; end
        n_vec++; if (a_frames !== 16'd1) begin $display("FAIL illegal_frames: got %0d want 1", a_frames); n_err++; end
        tick();
        n_vec++; if (a_err !== 1'b0 || a_strobe !== 20'h0) begin
            $display("FAIL illegal_after: got err=%b strobe=%h want 0/0", a_err, a_strobe); n_err++; end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_strobe;
        b_valid = 1'b1; b_addr = 5'd19; b_data = 32'h1111_2222;
        for (int k = 1; k <= 8; k++) begin
            tick();
            b_valid = 1'b0;
            exp_strobe = (k == 4 || k == 5) ? 20'h80000 : 20'h0;
            n_vec++; if (b_strobe !== exp_strobe) begin
                $display("FAIL b2b_strobe T+%0d: got %h want %h", k, b_strobe, exp_strobe); n_err++; end
            n_vec++; if (b_done !== (k == 8)) begin
                $display("FAIL b2b_done T+%0d: got %b want %b", k, b_done, (k == 8)); n_err++; end
        end
        n_vec++; if (b_ready !== 1'b1) begin $display("FAIL b2b_ready: got %b want 1", b_ready); n_err++; end
        // Second command offered in the done cycle.
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h3333_4444;
        for (int k = 9; k <= 16; k++) begin
            tick();
            b_valid = 1'b0;
            exp_strobe = (k == 12 || k == 13) ? 20'h00001 : 20'h0;
            n_vec++; if (b_strobe !== exp_strobe) begin
                $display("FAIL b2b2_strobe T+%0d: got %h want %h", k, b_strobe, exp_strobe); n_err++; end
            if (k == 9) begin
                n_vec++; if (b_fdata !== 32'h3333_4444) begin
                    $display("FAIL b2b2_fdata: got %h want 33334444", b_fdata); n_err++; end
            end
        end
        n_vec++; if (b_done !== 1'b1 || b_frames !== 16'd2) begin
            $display("FAIL b2b2_done: got done=%b frames=%0d want 1/2", b_done, b_frames); n_err++; end
        tick();
    endtask

    task automatic test_abort_setup();
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h5555_6666;
        tick();  // T+1, first SETUP cycle
        b_valid = 1'b0;
        b_abort = 1'b1;
        tick();  // T+2
        b_abort = 1'b0;
        n_vec++; if (b_aborted !== 1'b1) begin $display("FAIL abort_pulse: got %b want 1", b_aborted); n_err++; end
        n_vec++; if (b_busy !== 1'b0 || b_ready !== 1'b1) begin
            $display("FAIL abort_idle: got busy=%b ready=%b want 0/1", b_busy, b_ready); n_err++; end
        n_vec++; if (b_fdata !== 32'h5555_6666) begin $display("FAIL abort_fdata: got %h want 55556666", b_fdata); n_err++; end
        for (int k = 3; k <= 8; k++) begin
            n_vec++; if (b_strobe !== 20'h0 || b_done !== 1'b0) begin
                $display("FAIL abort_nostrobe T+%0d: got strobe=%h done=%b want 0/0", k, b_strobe, b_done);
                n_err++; end
            tick();
        end
        n_vec++; if (b_aborted !== 1'b0) begin $display("FAIL abort_pulse_end: got %b want 0", b_aborted); n_err++; end
        n_vec++; if (b_frames !== 16'd2) begin $display("FAIL abort_frames: got %0d want 2", b_frames); n_err++; end
    endtask

    task automatic test_abort_strobe();
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h7777_8888;
        for (int k = 1; k <= 4; k++) begin
            tick();
            b_valid = 1'b0;
        end
        n_vec++; if (b_strobe !== 20'h00008) begin $display("FAIL abstr_strobe: got %h want 00008", b_strobe); n_err++; end
        b_abort = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            tick();
            n_vec++; if (b_aborted !== 1'b0) begin
                $display("FAIL abstr_aborted T+%0d: got %b want 0", k, b_aborted); n_err++; end
        end
        b_abort = 1'b0;
        n_vec++; if (b_done !== 1'b1 || b_frames !== 16'd3) begin
            $display("FAIL abstr_done: got done=%b frames=%0d want 1/3", b_done, b_frames); n_err++; end
        tick();
    endtask

    task automatic test_async_reset();
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1234_5678;
        tick();
        a_valid = 1'b0;
        tick();  // T+2, strobe high
        n_vec++; if (a_strobe !== 20'h00200) begin $display("FAIL arst_pre: got %h want 00200", a_strobe); n_err++; end
        #3 rst = 1'b1;
        #1;
        n_vec++; if (a_strobe !== 20'h0) begin $display("FAIL arst_strobe: got %h want 0", a_strobe); n_err++; end
        n_vec++; if (a_fdata !== 32'h0) begin $display("FAIL arst_fdata: got %h want 0", a_fdata); n_err++; end
        n_vec++; if (a_busy !== 1'b0 || a_frames !== 16'd0) begin
            $display("FAIL arst_state: got busy=%b frames=%0d want 0/0", a_busy, a_frames); n_err++; end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (a_done !== 1'b0 || a_strobe !== 20'h0) begin
                $display("FAIL arst_nodone: got done=%b strobe=%h want 0/0", a_done, a_strobe); n_err++; end
        end
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hCAFE_F00D;
        tick();
        a_valid = 1'b0;
        tick();
        n_vec++; if (a_strobe !== 20'h00001) begin $display("FAIL arst_next_strobe: got %h want 00001", a_strobe); n_err++; end
        tick();
        tick();
        n_vec++; if (a_done !== 1'b1 || a_frames !== 16'd1) begin
            $display("FAIL arst_next_done: got done=%b frames=%0d want 1/1", a_done, a_frames); n_err++; end
        tick();
    endtask

    task automatic test_saturation();
        logic [3:0] exp_frames;
        n_vec++; if (c_frames !== 4'd0) begin $display("FAIL sat_start: got %0d want 0", c_frames); n_err++; end
        for (int i = 0; i < 17; i++) begin
            c_valid = 1'b1; c_addr = 5'(i % 20); c_data = 32'(i) + 32'h0100;
            tick();
            c_valid = 1'b0;
            tick();
            tick();
            tick();  // done cycle; next command issued here
            exp_frames = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            n_vec++; if (c_done !== 1'b1 || c_frames !== exp_frames) begin
                $display("FAIL sat_write %0d: got done=%b frames=%0d want 1/%0d", i, c_done, c_frames,
                         exp_frames);
                n_err++; end
        end
        tick();
        n_vec++; if (c_frames !== 4'd15) begin $display("FAIL sat_final: got %0d want 15", c_frames); n_err++; end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0; a_abort = 1'b0;
        b_valid = 1'b0; b_addr = '0; b_data = '0; b_abort = 1'b0;
        c_valid = 1'b0; c_addr = '0; c_data = '0; c_abort = 1'b0;
        #2;
        test_reset();
        test_basic_write();
        test_illegal_addr();
        test_back_to_back();
        test_abort_setup();
        test_abort_strobe();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
